// File: rtl/cache_axi_bridge.sv
// Cache miss/refill responder and AXI3 master: one read and one write in flight, each
// turned into a single INCR burst (4 beats for a line, 1 beat otherwise).
module cache_axi_bridge #(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         data_write_ok,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic [1:0]   arlock,
  output logic [3:0]   arcache,
  output logic [2:0]   arprot,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic [1:0]   awlock,
  output logic [3:0]   awcache,
  output logic [2:0]   awprot,
  output logic         awvalid,
  input  logic         awready,
  output logic [3:0]   wid,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  localparam logic [2:0] TypeLine = 3'd4;

  typedef enum logic [1:0] {RIdle, RAr, RData} r_state_e;
  typedef enum logic [1:0] {WIdle, WAw, WData, WB} w_state_e;

  r_state_e       r_state_q, r_state_d;
  w_state_e       w_state_q, w_state_d;
  logic [31:0]    rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [2:0]     rd_type_q, rd_type_d, wr_type_q, wr_type_d;
  logic [3:0]     wr_wstrb_q, wr_wstrb_d;
  logic [127:0]   wr_data_q, wr_data_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           rd_accept, wr_accept, hazard, rd_line, wr_line;
  logic [1:0]     word_sel;

  // Response IDs and error codes are deliberately not checked.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, bid, bresp};

  // Blocks a read from overtaking a pending write to the same line.
  assign hazard    = (w_state_q != WIdle) && (rd_addr[31:4] == wr_addr_q[31:4]);
  assign rd_rdy    = (r_state_q == RIdle) && !hazard;
  assign wr_rdy    = (w_state_q == WIdle);
  assign rd_accept = rd_req && rd_rdy;
  assign wr_accept = wr_req && wr_rdy;
  assign rd_line   = (rd_type_q == TypeLine);
  assign wr_line   = (wr_type_q == TypeLine);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_q  <= RIdle;
      w_state_q  <= WIdle;
      rd_addr_q  <= '0;
      rd_type_q  <= '0;
      wr_addr_q  <= '0;
      wr_type_q  <= '0;
      wr_wstrb_q <= '0;
      wr_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      r_state_q  <= r_state_d;
      w_state_q  <= w_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_type_q  <= rd_type_d;
      wr_addr_q  <= wr_addr_d;
      wr_type_q  <= wr_type_d;
      wr_wstrb_q <= wr_wstrb_d;
      wr_data_q  <= wr_data_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    rd_addr_d = rd_addr_q;
    rd_type_d = rd_type_q;
    unique case (r_state_q)
      RIdle: if (rd_accept) begin
        r_state_d = RAr;
        rd_addr_d = rd_addr;
        rd_type_d = rd_type;
      end
      RAr:   if (arready) r_state_d = RData;
      RData: if (rvalid && rlast) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  always_comb begin
    w_state_d  = w_state_q;
    wr_addr_d  = wr_addr_q;
    wr_type_d  = wr_type_q;
    wr_wstrb_d = wr_wstrb_q;
    wr_data_d  = wr_data_q;
    cnt_d      = cnt_q;
    unique case (w_state_q)
      WIdle: if (wr_accept) begin
        w_state_d  = WAw;
        wr_addr_d  = wr_addr;
        wr_type_d  = wr_type;
        wr_wstrb_d = wr_wstrb;
        wr_data_d  = wr_data;
        cnt_d      = 2'd0;
      end
      WAw:   if (awready) w_state_d = WData;
      WData: if (wready) begin
        cnt_d = cnt_q + 2'd1;
        if (wlast) w_state_d = WB;
      end
      WB:    if (bvalid) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    arid      = RD_ID;
    araddr    = rd_line ? {rd_addr_q[31:4], 4'b0} : rd_addr_q;
    arlen     = rd_line ? 8'd3 : 8'd0;
    arsize    = rd_line ? 3'd2 : {1'b0, rd_type_q[1:0]};
    arburst   = 2'b01;
    arlock    = '0;
    arcache   = '0;
    arprot    = '0;
    arvalid   = (r_state_q == RAr);
    rready    = (r_state_q == RData);
    ret_valid = rready && rvalid;
    ret_last  = ret_valid && rlast;
    ret_data  = ret_valid ? rdata : 32'd0;
  end

  always_comb begin
    word_sel      = wr_line ? cnt_q : wr_addr_q[3:2];
    awid          = WR_ID;
    awaddr        = wr_line ? {wr_addr_q[31:4], 4'b0} : wr_addr_q;
    awlen         = wr_line ? 8'd3 : 8'd0;
    awsize        = wr_line ? 3'd2 : {1'b0, wr_type_q[1:0]};
    awburst       = 2'b01;
    awlock        = '0;
    awcache       = '0;
    awprot        = '0;
    awvalid       = (w_state_q == WAw);
    wid           = WR_ID;
    wvalid        = (w_state_q == WData);
    wdata         = wr_data_q[32*word_sel +: 32];
    wstrb         = wr_line ? 4'hf : wr_wstrb_q;
    wlast         = wvalid && (wr_line ? (cnt_q == 2'd3) : 1'b1);
    bready        = (w_state_q == WB);
    data_write_ok = bready && bvalid;
  end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: the bench plays both cache and AXI slave, driving
// inputs on the falling edge and checking outputs 1 ns later.
module tb_cache_axi_bridge;

  logic         clk = 1'b0, reset = 1'b1;
  logic         rd_req = 0, wr_req = 0;
  logic [2:0]   rd_type = 0, wr_type = 0;
  logic [31:0]  rd_addr = 0, wr_addr = 0;
  logic [3:0]   wr_wstrb = 0;
  logic [127:0] wr_data = 0;
  logic         rd_rdy, ret_valid, ret_last, wr_rdy, data_write_ok;
  logic [31:0]  ret_data;
  logic [3:0]   arid, awid, wid, wstrb;
  logic [31:0]  araddr, awaddr, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize, arprot, awprot;
  logic [1:0]   arburst, awburst, arlock, awlock;
  logic [3:0]   arcache, awcache;
  logic         arvalid, awvalid, wvalid, wlast, rready, bready;
  logic         arready = 0, rlast = 0, rvalid = 0, awready = 0, wready = 0, bvalid = 0;
  logic [3:0]   rid = 0, bid = 0;
  logic [1:0]   rresp = 0, bresp = 0;
  logic [31:0]  rdata = 0;

  int n_asserts = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cache_axi_bridge dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy), .data_write_ok(data_write_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    // Reset state, checked while reset is held
    step(); step();
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_ret_last", ret_last, 0);
    chk("rst_dwo", data_write_ok, 0);
    chk("rst_rd_rdy", rd_rdy, 1);
    chk("rst_wr_rdy", wr_rdy, 1);
    chk("rst_araddr", araddr, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wlast", wlast, 0);
    step(); reset = 0;

    // Stray B response with no write pending
    bvalid = 1; #1;
    chk("stray_bready", bready, 0);
    chk("stray_dwo", data_write_ok, 0);
    step(); bvalid = 0;

    // Line read with AR and R delays
    rd_req = 1; rd_type = 3'd4; rd_addr = 32'h1C00_0134; #1;
    chk("lr_rd_rdy", rd_rdy, 1);
    step(); rd_req = 0; #1;
    chk("lr_arvalid", arvalid, 1);
    chk("lr_araddr", araddr, 32'h1C00_0130);
    chk("lr_arlen", arlen, 3);
    chk("lr_arsize", arsize, 2);
    chk("lr_arburst", arburst, 1);
    chk("lr_arid", arid, 0);
    chk("lr_rd_rdy_busy", rd_rdy, 0);
    step(); arready = 1; #1;
    chk("lr_arvalid_held", arvalid, 1);
    chk("lr_araddr_held", araddr, 32'h1C00_0130);
    step(); arready = 0; #1;
    chk("lr_arvalid_done", arvalid, 0);
    chk("lr_rready", rready, 1);
    chk("lr_ret_idle", ret_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step(); rvalid = 1; rdata = 32'hA0 + i; rlast = (i == 3); #1;
      chk("lr_ret_valid", ret_valid, 1);
      chk("lr_ret_data", ret_data, 32'hA0 + i);
      chk("lr_ret_last", ret_last, (i == 3));
      if (i == 1) begin
        step(); rvalid = 0; #1;
        chk("lr_gap_ret_valid", ret_valid, 0);
      end
    end
    step(); rvalid = 0; rlast = 0; #1;
    chk("lr_rd_rdy_back", rd_rdy, 1);
    chk("lr_rready_off", rready, 0);

    // Uncached byte read
    rd_req = 1; rd_type = 3'd0; rd_addr = 32'h1FAF_0003;
    step(); rd_req = 0; arready = 1; #1;
    chk("br_araddr", araddr, 32'h1FAF_0003);
    chk("br_arlen", arlen, 0);
    chk("br_arsize", arsize, 0);
    chk("br_arvalid", arvalid, 1);
    step(); arready = 0; rvalid = 1; rlast = 1; rdata = 32'h55; #1;
    chk("br_ret_valid", ret_valid, 1);
    chk("br_ret_last", ret_last, 1);
    chk("br_ret_data", ret_data, 32'h55);
    step(); rvalid = 0; rlast = 0; #1;
    chk("br_rd_rdy", rd_rdy, 1);

    // Line write with wready toggling
    wr_req = 1; wr_type = 3'd4; wr_addr = 32'h0000_1040; wr_wstrb = 4'h0;
    wr_data = {32'h4, 32'h3, 32'h2, 32'h1}; #1;
    chk("lw_wr_rdy", wr_rdy, 1);
    step(); wr_req = 0; #1;
    chk("lw_awvalid", awvalid, 1);
    chk("lw_awaddr", awaddr, 32'h1040);
    chk("lw_awlen", awlen, 3);
    chk("lw_awsize", awsize, 2);
    chk("lw_awid", awid, 1);
    chk("lw_wvalid_early", wvalid, 0);
    awready = 1;
    step(); awready = 0; #1;
    chk("lw_awvalid_done", awvalid, 0);
    for (int i = 0; i < 4; i++) begin
      wready = 0; #1;
      chk("lw_wvalid_held", wvalid, 1);
      chk("lw_wdata_held", wdata, i + 1);
      step(); wready = 1; #1;
      chk("lw_wdata", wdata, i + 1);
      chk("lw_wstrb", wstrb, 4'hf);
      chk("lw_wlast", wlast, (i == 3));
      step();
    end
    wready = 0; #1;
    chk("lw_wvalid_off", wvalid, 0);
    chk("lw_bready", bready, 1);
    chk("lw_dwo_wait", data_write_ok, 0);
    step(); bvalid = 1; #1;
    chk("lw_dwo", data_write_ok, 1);
    chk("lw_wr_rdy_busy", wr_rdy, 0);
    step(); bvalid = 0; #1;
    chk("lw_dwo_pulse", data_write_ok, 0);
    chk("lw_wr_rdy_back", wr_rdy, 1);

    // Uncached word write, word 2 selected by addr[3:2]
    wr_req = 1; wr_type = 3'd2; wr_addr = 32'h1FAF_F008; wr_wstrb = 4'h3;
    wr_data = {4{32'hDEAD_BEEF}};
    step(); wr_req = 0; awready = 1; #1;
    chk("uw_awaddr", awaddr, 32'h1FAF_F008);
    chk("uw_awlen", awlen, 0);
    chk("uw_awsize", awsize, 2);
    step(); awready = 0; wready = 1; #1;
    chk("uw_wdata", wdata, 32'hDEAD_BEEF);
    chk("uw_wstrb", wstrb, 4'h3);
    chk("uw_wlast", wlast, 1);
    step(); wready = 0; bvalid = 1; #1;
    chk("uw_dwo", data_write_ok, 1);
    step(); bvalid = 0; #1;
    chk("uw_wr_rdy", wr_rdy, 1);

    // Hazard: pending line write to 0x2000 blocks a read to 0x2008 only
    wr_req = 1; wr_type = 3'd4; wr_addr = 32'h2000; wr_data = {32'h8, 32'h7, 32'h6, 32'h5};
    step(); wr_req = 0; awready = 1;
    rd_req = 1; rd_type = 3'd4; rd_addr = 32'h2008; #1;
    chk("hz_rd_rdy_aw", rd_rdy, 0);
    step(); awready = 0; wready = 1;
    for (int i = 0; i < 4; i++) begin
      #1; chk("hz_rd_rdy_w", rd_rdy, 0);
      step();
    end
    wready = 0; #1;
    chk("hz_bready", bready, 1);
    chk("hz_rd_rdy_b", rd_rdy, 0);
    rd_type = 3'd2; rd_addr = 32'h3000; #1;
    chk("hz_other_rdy", rd_rdy, 1);
    step(); rd_req = 0; arready = 1; #1;
    chk("hz_other_araddr", araddr, 32'h3000);
    chk("hz_other_arvalid", arvalid, 1);
    step(); arready = 0; rvalid = 1; rlast = 1; rdata = 32'h33; #1;
    chk("hz_other_ret", ret_data, 32'h33);
    step(); rvalid = 0; rlast = 0;
    rd_req = 1; rd_type = 3'd4; rd_addr = 32'h2008; #1;
    chk("hz_still_blocked", rd_rdy, 0);
    bvalid = 1; #1;
    chk("hz_blocked_at_b", rd_rdy, 0);
    chk("hz_dwo", data_write_ok, 1);
    step(); bvalid = 0; #1;
    chk("hz_released", rd_rdy, 1);

    // Reset in the middle of that line read, after 2 beats
    step(); rd_req = 0; arready = 1; #1;
    chk("mr_araddr", araddr, 32'h2000);
    step(); arready = 0;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1; rdata = 32'hB0 + i; #1;
      chk("mr_ret_data", ret_data, 32'hB0 + i);
      step();
    end
    reset = 1; #1;
    chk("mr_rready", rready, 0);
    chk("mr_rd_rdy", rd_rdy, 1);
    chk("mr_ret_valid", ret_valid, 0);
    chk("mr_araddr_rst", araddr, 0);
    step(); reset = 0; rvalid = 0;
    rd_req = 1; rd_type = 3'd2; rd_addr = 32'h40; #1;
    chk("mr_new_rdy", rd_rdy, 1);
    step(); rd_req = 0; arready = 1; #1;
    chk("mr_new_arvalid", arvalid, 1);
    chk("mr_new_araddr", araddr, 32'h40);
    chk("mr_new_arlen", arlen, 0);
    step(); arready = 0; rvalid = 1; rlast = 1; rdata = 32'h77; #1;
    chk("mr_new_ret", ret_data, 32'h77);
    chk("mr_new_last", ret_last, 1);
    step(); rvalid = 0; rlast = 0; #1;
    chk("mr_new_idle", rd_rdy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
